// File: rtl/grid8_valve_sequencer_if.sv
// grid8_valve_sequencer_if: host command handshake bundle.
// Host drives the command fields; the sequencer returns cmd_ready.
interface grid8_valve_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_inlet;
    logic [7:0]       cmd_load_mask;
    logic [7:0]       cmd_flush_mask;
    logic [CNT_W-1:0] cmd_load_cyc;
    logic [CNT_W-1:0] cmd_flush_cyc;

    modport master (
        output cmd_valid,
        output cmd_inlet,
        output cmd_load_mask,
        output cmd_flush_mask,
        output cmd_load_cyc,
        output cmd_flush_cyc,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_inlet,
        input  cmd_load_mask,
        input  cmd_flush_mask,
        input  cmd_load_cyc,
        input  cmd_flush_cyc,
        output cmd_ready
    );
endinterface

// File: rtl/grid8_valve_sequencer.sv
// grid8_valve_sequencer: inlet/settle/load/flush/done valve sequencer.
// Optional break-before-make on route change: define GRID8_SEQ_BBM_EN.
module grid8_valve_sequencer #(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int BBM_CYCLES    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    grid8_valve_sequencer_if.slave cmd,
    input  logic                  abort,
    output logic [5:0]            c_open,
    output logic [7:0]            d_open,
    output logic [7:0]            e_open,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES >= (2 ** CNT_W)) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range");
    end
    if (BBM_CYCLES < 1 || BBM_CYCLES > 255) begin : g_bad_bbm
        $error("BBM_CYCLES out of range");
    end

    localparam logic [CNT_W-1:0] S_LD = CNT_W'(SETTLE_CYCLES);
`ifdef GRID8_SEQ_BBM_EN
    localparam logic [CNT_W-1:0] B_LD = CNT_W'(BBM_CYCLES);
`endif

    typedef enum logic [2:0] {
        IDLE,
`ifdef GRID8_SEQ_BBM_EN
        BBM,
`endif
        SETTLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       inlet_q;
    logic [7:0]       load_mask_q;
    logic [7:0]       flush_mask_q;
    logic [CNT_W-1:0] load_cyc_q;
    logic [CNT_W-1:0] flush_cyc_q;
    logic [5:0]       c_n;
    logic [7:0]       d_n;
    logic [7:0]       e_n;
    logic             busy_n;
    logic             done_n;
    logic             aborted_n;
    logic             accept;

    function automatic logic [5:0] route(input logic [2:0] n);
        route = {n[2], ~n[2], n[1], ~n[1], n[0], ~n[0]};
    endfunction

    assign cmd.cmd_ready = (state == IDLE) & ~abort;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;

    // Next-state, counter and next-output decode for the phase sequence.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        c_n       = c_open;
        aborted_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SETTLE;
                    cnt_n   = S_LD;
                    c_n     = route(cmd.cmd_inlet);
`ifdef GRID8_SEQ_BBM_EN
                    if (c_open != 6'd0 && route(cmd.cmd_inlet) != c_open) begin
                        state_n = BBM;
                        cnt_n   = B_LD;
                        c_n     = 6'd0;
                    end
`endif
                end
            end
`ifdef GRID8_SEQ_BBM_EN
            BBM: begin
                if (cnt == 1) begin
                    state_n = SETTLE;
                    cnt_n   = S_LD;
                    c_n     = route(inlet_q);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`endif
            SETTLE: begin
                if (cnt == 1) begin
                    if (load_cyc_q != 0) begin
                        state_n = LOAD;
                        cnt_n   = load_cyc_q;
                    end else if (flush_cyc_q != 0) begin
                        state_n = FLUSH;
                        cnt_n   = flush_cyc_q;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            LOAD: begin
                if (cnt == 1) begin
                    if (flush_cyc_q != 0) begin
                        state_n = FLUSH;
                        cnt_n   = flush_cyc_q;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            FLUSH: begin
                if (cnt == 1) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort && state != IDLE) begin
            state_n   = IDLE;
            c_n       = 6'd0;
            aborted_n = 1'b1;
        end
        d_n    = (state_n == LOAD)  ? load_mask_q  : 8'd0;
        e_n    = (state_n == FLUSH) ? flush_mask_q : 8'd0;
        done_n = (state_n == DONE);
        busy_n = (state_n != IDLE);
    end

    // State, counter and registered valve/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            c_open  <= 6'd0;
            d_open  <= 8'd0;
            e_open  <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            c_open  <= c_n;
            d_open  <= d_n;
            e_open  <= e_n;
            busy    <= busy_n;
            done    <= done_n;
            aborted <= aborted_n;
        end
    end

    // Command fields are captured only on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inlet_q      <= 3'd0;
            load_mask_q  <= 8'd0;
            flush_mask_q <= 8'd0;
            load_cyc_q   <= '0;
            flush_cyc_q  <= '0;
        end else if (accept) begin
            inlet_q      <= cmd.cmd_inlet;
            load_mask_q  <= cmd.cmd_load_mask;
            flush_mask_q <= cmd.cmd_flush_mask;
            load_cyc_q   <= cmd.cmd_load_cyc;
            flush_cyc_q  <= cmd.cmd_flush_cyc;
        end
    end

endmodule

// File: tb/tb_grid8_valve_sequencer.sv
// tb_grid8_valve_sequencer: scoreboard bench for the valve sequencer.
// Expected per-cycle valve snapshots are queued; a monitor pops and compares.
module tb_grid8_valve_sequencer;
    localparam int CNT_W = 16;
    localparam int S     = 8;
    localparam int BB    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] c_open;
    logic [7:0] d_open;
    logic [7:0] e_open;
    logic       busy;
    logic       done;
    logic       aborted;

    always #5 clk = ~clk;

    grid8_valve_sequencer_if #(.CNT_W(CNT_W)) cmd_if ();

    grid8_valve_sequencer #(
        .CNT_W(CNT_W),
        .SETTLE_CYCLES(S),
        .BBM_CYCLES(BB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd_if.slave),
        .abort(abort),
        .c_open(c_open),
        .d_open(d_open),
        .e_open(e_open),
        .busy(busy),
        .done(done),
        .aborted(aborted)
    );

    typedef struct packed {
        logic [5:0] c;
        logic [7:0] d;
        logic [7:0] e;
        logic       busy;
        logic       done;
        logic       aborted;
    } snap_t;

    snap_t      exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [5:0] c_model = 6'd0;

    function automatic logic [5:0] route(input logic [2:0] n);
        route = {n[2], ~n[2], n[1], ~n[1], n[0], ~n[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [5:0] c, input logic [7:0] d, input logic [7:0] e,
                        input logic b, input logic dn, input logic ab);
        snap_t s;
        s = '{c: c, d: d, e: e, busy: b, done: dn, aborted: ab};
        exp_q.push_back(s);
    endtask

    // Monitor: every cycle the DUT shows activity, compare against the queue head.
    always @(negedge clk) begin
        snap_t a;
        snap_t x;
        if (rst_n && (busy || done || aborted)) begin
            a = '{c: c_open, d: d_open, e: e_open, busy: busy, done: done, aborted: aborted};
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got c=%b d=%h e=%h busy=%b done=%b ab=%b, none expected",
                         a.c, a.d, a.e, a.busy, a.done, a.aborted);
            end else begin
                x = exp_q.pop_front();
                if (a !== x) begin
                    n_fail++;
                    $display("FAIL cycle_snapshot: got c=%b d=%h e=%h busy=%b done=%b ab=%b expected c=%b d=%h e=%h busy=%b done=%b ab=%b",
                             a.c, a.d, a.e, a.busy, a.done, a.aborted,
                             x.c, x.d, x.e, x.busy, x.done, x.aborted);
                end
            end
        end
    end

    task automatic run_cmd(input logic [2:0] inl, input logic [7:0] lm, input logic [7:0] fm,
                           input int L, input int F, input int abort_at, input int rst_at);
        logic [5:0] r;
        int         b;
        int         n;
        int         last;
        r = route(inl);
        b = 0;
`ifdef GRID8_SEQ_BBM_EN
        if (c_model != 6'd0 && c_model != r) b = BB;
`endif
        n = b + S + L + F + 1;
        last = (abort_at != 0) ? abort_at : ((rst_at != 0) ? rst_at : n);
        for (int k = 1; k <= last; k++) begin
            if (k <= b)                push(6'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
            else if (k <= b + S)       push(r, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
            else if (k <= b + S + L)   push(r, lm, 8'd0, 1'b1, 1'b0, 1'b0);
            else if (k <= b+S+L+F)     push(r, 8'd0, fm, 1'b1, 1'b0, 1'b0);
            else                       push(r, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
        end
        if (abort_at != 0) push(6'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        abort                 = 1'b0;
        cmd_if.cmd_inlet      = inl;
        cmd_if.cmd_load_mask  = lm;
        cmd_if.cmd_flush_mask = fm;
        cmd_if.cmd_load_cyc   = CNT_W'(L);
        cmd_if.cmd_flush_cyc  = CNT_W'(F);
        cmd_if.cmd_valid      = 1'b1;
        #1;
        check("ready_at_accept", {31'd0, cmd_if.cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid      = 1'b0;
        cmd_if.cmd_inlet      = ~inl;
        cmd_if.cmd_load_mask  = ~lm;
        cmd_if.cmd_flush_mask = ~fm;
        cmd_if.cmd_load_cyc   = 16'd1;
        cmd_if.cmd_flush_cyc  = 16'd1;

        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == abort_at) abort = 1'b1;
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_c_open", {26'd0, c_open}, 32'd0);
                check("rst_d_open", {24'd0, d_open}, 32'd0);
                check("rst_e_open", {24'd0, e_open}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_aborted", {31'd0, aborted}, 32'd0);
            end else begin
                @(posedge clk);
                #1 abort = 1'b0;
            end
        end

        if (rst_at != 0) begin
            c_model = 6'd0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("rst_queue_drained", exp_q.size(), 32'd0);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            #1;
            check("idle_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("queue_drained", exp_q.size(), 32'd0);
            if (abort_at != 0) begin
                check("abort_clears_route", {26'd0, c_open}, 32'd0);
                c_model = 6'd0;
            end else begin
                check("route_retained", {26'd0, c_open}, {26'd0, r});
                c_model = r;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_if.cmd_valid      = 1'b0;
        cmd_if.cmd_inlet      = 3'd0;
        cmd_if.cmd_load_mask  = 8'd0;
        cmd_if.cmd_flush_mask = 8'd0;
        cmd_if.cmd_load_cyc   = '0;
        cmd_if.cmd_flush_cyc  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_c_open", {26'd0, c_open}, 32'd0);
        check("reset_d_open", {24'd0, d_open}, 32'd0);
        check("reset_e_open", {24'd0, e_open}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_aborted", {31'd0, aborted}, 32'd0);
        check("reset_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

        run_cmd(3'd5, 8'h0F, 8'hF0, 3, 2, 0, 0);
        run_cmd(3'd2, 8'h81, 8'h18, 1, 1, 0, 0);
        run_cmd(3'd7, 8'hFF, 8'hFF, 0, 0, 0, 0);
`ifdef GRID8_SEQ_BBM_EN
        run_cmd(3'd3, 8'h3C, 8'hC3, 4, 2, BB + S + 2, 0);
`else
        run_cmd(3'd3, 8'h3C, 8'hC3, 4, 2, S + 2, 0);
`endif

        @(negedge clk);
        abort                 = 1'b1;
        cmd_if.cmd_valid      = 1'b1;
        cmd_if.cmd_inlet      = 3'd1;
        #1;
        check("idle_abort_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_abort_busy", {31'd0, busy}, 32'd0);
            check("idle_abort_no_pulse", {31'd0, aborted}, 32'd0);
        end
        run_cmd(3'd1, 8'h55, 8'hAA, 3, 5, 0, S + 3 + 2);
        run_cmd(3'd0, 8'h42, 8'h24, 2, 0, 0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
